// File: rtl/miter_timing_checker.sv
// rtl/miter_timing_checker.sv - lockstep miter comparing two CPU copies' fetch/data request streams
//
// Purpose: after arming and a warm-up delay, compares the instruction and data
// request interfaces of two redundant copies (A and B) every cycle. The first
// mismatch latches its cause and CHECK-cycle index and parks the checker in a
// sticky DIVERGED state that only rst releases.
//
// Optional feature: define MITER_DWDATA_CMP_EN to also compare store data on
// cycles where both copies issue a write (div_cause bit4). Without it the
// dwdata ports are accepted but ignored and bit4 stays 0.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   arm                          checking enabled while high
//   ivalid_a/b, iaddr_a/b        instruction fetch valid/address per copy
//   dvalid_a/b, dwrite_a/b       data request valid/write flag per copy
//   daddr_a/b, dwdata_a/b        data request address/store data per copy
//   state                        IDLE=00, WARMUP=01, CHECK=10, DIVERGED=11
//   diverged                     sticky divergence flag
//   div_cause                    latched mismatch bits {dwdata, dwrite/daddr, dvalid, iaddr, ivalid}
//   div_cycle                    CHECK-cycle index of the divergence
//   match_count                  CHECK cycles with a matching valid transfer (saturating)
module miter_timing_checker #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int CNT_W  = 16,
    parameter int WARMUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             ivalid_a,
    input  logic             ivalid_b,
    input  logic [AW-1:0]    iaddr_a,
    input  logic [AW-1:0]    iaddr_b,
    input  logic             dvalid_a,
    input  logic             dvalid_b,
    input  logic             dwrite_a,
    input  logic             dwrite_b,
    input  logic [AW-1:0]    daddr_a,
    input  logic [AW-1:0]    daddr_b,
    input  logic [DW-1:0]    dwdata_a,
    input  logic [DW-1:0]    dwdata_b,
    output logic [1:0]       state,
    output logic             diverged,
    output logic [4:0]       div_cause,
    output logic [CNT_W-1:0] div_cycle,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WARMUP   = 2'b01,
        S_CHECK    = 2'b10,
        S_DIVERGED = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [7:0]       WARMUP_INIT = 8'(WARMUP);

    state_t           state_q, state_d;
    logic [7:0]       warm_q, warm_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic             div_q, div_d;
    logic [4:0]       cause_q, cause_d;
    logic [CNT_W-1:0] divcyc_q, divcyc_d;

    logic [4:0]       cause;
    logic             pair_valid;

    // Per-cycle mismatch vector; address/flag fields only matter when both
    // copies assert the corresponding valid.
    always_comb begin
        cause    = '0;
        cause[0] = ivalid_a ^ ivalid_b;
        cause[1] = ivalid_a & ivalid_b & (iaddr_a != iaddr_b);
        cause[2] = dvalid_a ^ dvalid_b;
        cause[3] = dvalid_a & dvalid_b & ((dwrite_a ^ dwrite_b) | (daddr_a != daddr_b));
`ifdef MITER_DWDATA_CMP_EN
        cause[4] = dvalid_a & dvalid_b & dwrite_a & dwrite_b & (dwdata_a != dwdata_b);
`endif
    end

`ifndef MITER_DWDATA_CMP_EN
    logic unused_dwdata;
    assign unused_dwdata = ^{dwdata_a, dwdata_b};
`endif

    assign pair_valid = (ivalid_a & ivalid_b) | (dvalid_a & dvalid_b);

    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        cyc_d    = cyc_q;
        match_d  = match_q;
        div_d    = div_q;
        cause_d  = cause_q;
        divcyc_d = divcyc_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    if (WARMUP == 0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_WARMUP;
                        warm_d  = WARMUP_INIT;
                    end
                end
            end
            S_WARMUP: begin
                if (!arm) begin
                    state_d = S_IDLE;
                    warm_d  = '0;
                    cyc_d   = '0;
                    match_d = '0;
                end else if (warm_q <= 8'd1) begin
                    state_d = S_CHECK;
                    warm_d  = '0;
                end else begin
                    warm_d = warm_q - 8'd1;
                end
            end
            S_CHECK: begin
                // Divergence takes priority over disarming in the same cycle.
                if (cause != 5'd0) begin
                    state_d  = S_DIVERGED;
                    div_d    = 1'b1;
                    cause_d  = cause;
                    divcyc_d = cyc_q;
                end else if (!arm) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                    match_d = '0;
                end else begin
                    if (cyc_q != CNT_MAX) begin
                        cyc_d = cyc_q + 1'b1;
                    end
                    if (pair_valid && match_q != CNT_MAX) begin
                        match_d = match_q + 1'b1;
                    end
                end
            end
            default: begin
                // DIVERGED: everything holds until rst.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            warm_q   <= '0;
            cyc_q    <= '0;
            match_q  <= '0;
            div_q    <= 1'b0;
            cause_q  <= '0;
            divcyc_q <= '0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            cyc_q    <= cyc_d;
            match_q  <= match_d;
            div_q    <= div_d;
            cause_q  <= cause_d;
            divcyc_q <= divcyc_d;
        end
    end

    assign state       = state_q;
    assign diverged    = div_q;
    assign div_cause   = cause_q;
    assign div_cycle   = divcyc_q;
    assign match_count = match_q;

endmodule

// File: tb/tb_miter_timing_checker.sv
// tb/tb_miter_timing_checker.sv - self-checking bench for miter_timing_checker
module tb_miter_timing_checker;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WU = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, arm;
    logic          ivalid_a, ivalid_b, dvalid_a, dvalid_b, dwrite_a, dwrite_b;
    logic [AW-1:0] iaddr_a, iaddr_b, daddr_a, daddr_b;
    logic [DW-1:0] dwdata_a, dwdata_b;

    logic [1:0]  state_w, state_n;
    logic        div_w, div_n;
    logic [4:0]  cause_w, cause_n;
    logic [15:0] divcyc_w, match_w;
    logic [3:0]  divcyc_n, match_n;

    miter_timing_checker #(.AW(AW), .DW(DW), .CNT_W(16), .WARMUP(WU)) dut_w (
        .clk(clk), .rst(rst), .arm(arm),
        .ivalid_a(ivalid_a), .ivalid_b(ivalid_b), .iaddr_a(iaddr_a), .iaddr_b(iaddr_b),
        .dvalid_a(dvalid_a), .dvalid_b(dvalid_b), .dwrite_a(dwrite_a), .dwrite_b(dwrite_b),
        .daddr_a(daddr_a), .daddr_b(daddr_b), .dwdata_a(dwdata_a), .dwdata_b(dwdata_b),
        .state(state_w), .diverged(div_w), .div_cause(cause_w),
        .div_cycle(divcyc_w), .match_count(match_w)
    );

    miter_timing_checker #(.AW(AW), .DW(DW), .CNT_W(4), .WARMUP(WU)) dut_n (
        .clk(clk), .rst(rst), .arm(arm),
        .ivalid_a(ivalid_a), .ivalid_b(ivalid_b), .iaddr_a(iaddr_a), .iaddr_b(iaddr_b),
        .dvalid_a(dvalid_a), .dvalid_b(dvalid_b), .dwrite_a(dwrite_a), .dwrite_b(dwrite_b),
        .daddr_a(daddr_a), .daddr_b(daddr_b), .dwdata_a(dwdata_a), .dwdata_b(dwdata_b),
        .state(state_n), .diverged(div_n), .div_cause(cause_n),
        .div_cycle(divcyc_n), .match_count(match_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: tracks cycles elapsed since arming; phase and CHECK index derive from it.
    bit         m_live = 1'b0;
    bit         m_armed, m_div;
    int         m_elapsed, m_match, m_divcyc;
    logic [4:0] m_cause;

    function automatic logic [4:0] spec_cause();
        logic [4:0] c;
        c    = '0;
        c[0] = (ivalid_a != ivalid_b);
        c[1] = ivalid_a && ivalid_b && (iaddr_a != iaddr_b);
        c[2] = (dvalid_a != dvalid_b);
        c[3] = dvalid_a && dvalid_b && (dwrite_a != dwrite_b || daddr_a != daddr_b);
`ifdef MITER_DWDATA_CMP_EN
        c[4] = dvalid_a && dvalid_b && dwrite_a && dwrite_b && (dwdata_a != dwdata_b);
`endif
        return c;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_div) return 2'b11;
        if (!m_armed) return 2'b00;
        return (m_elapsed < WU) ? 2'b01 : 2'b10;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live    <= 1'b1;
            m_armed   <= 1'b0;
            m_div     <= 1'b0;
            m_elapsed <= 0;
            m_match   <= 0;
            m_divcyc  <= 0;
            m_cause   <= '0;
        end else if (m_div) begin
            m_div <= 1'b1;
        end else if (!m_armed) begin
            if (arm) begin
                m_armed   <= 1'b1;
                m_elapsed <= 0;
            end
        end else begin
            if (m_elapsed >= WU && spec_cause() != 5'd0) begin
                m_div    <= 1'b1;
                m_cause  <= spec_cause();
                m_divcyc <= m_elapsed - WU;
            end else if (!arm) begin
                m_armed <= 1'b0;
                m_match <= 0;
            end else begin
                if (m_elapsed >= WU && ((ivalid_a && ivalid_b) || (dvalid_a && dvalid_b)))
                    m_match <= m_match + 1;
                m_elapsed <= m_elapsed + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("w.state",  32'(state_w),  32'(exp_state()));
            chk("w.div",    32'(div_w),    32'(m_div));
            chk("w.cause",  32'(cause_w),  32'(m_cause));
            chk("w.divcyc", 32'(divcyc_w), 32'(sat(m_divcyc, 65535)));
            chk("w.match",  32'(match_w),  32'(sat(m_match, 65535)));
            chk("n.state",  32'(state_n),  32'(exp_state()));
            chk("n.div",    32'(div_n),    32'(m_div));
            chk("n.cause",  32'(cause_n),  32'(m_cause));
            chk("n.divcyc", 32'(divcyc_n), 32'(sat(m_divcyc, 15)));
            chk("n.match",  32'(match_n),  32'(sat(m_match, 15)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ivalid_a = 0; ivalid_b = 0; iaddr_a = '0; iaddr_b = '0;
        dvalid_a = 0; dvalid_b = 0; dwrite_a = 0; dwrite_b = 0;
        daddr_a = '0; daddr_b = '0; dwdata_a = '0; dwdata_b = '0;
    endtask

    task automatic pattern(input int i);
        ivalid_a = (i % 3 == 0); ivalid_b = ivalid_a;
        iaddr_a  = 32'(i * 4);   iaddr_b  = iaddr_a;
        dvalid_a = (i % 5 == 0); dvalid_b = dvalid_a;
        dwrite_a = i[0];         dwrite_b = dwrite_a;
        daddr_a  = 32'(32'h100 + i); daddr_b = daddr_a;
        dwdata_a = 32'(i);       dwdata_b = dwdata_a;
    endtask

    task automatic do_reset();
        rst = 1; arm = 0; idle_inputs();
        cyc(); cyc();
        rst = 0;
    endtask

    task automatic arm_to_check();
        arm = 1;
        cyc(); cyc(); cyc();
    endtask

    initial begin
        rst = 1; arm = 0; idle_inputs();
        @(negedge clk);
        do_reset();
        chk("rst.state", 32'(state_w), 32'd0);
        chk("rst.div",   32'(div_w),   32'd0);
        chk("rst.match", 32'(match_w), 32'd0);

        // Warm-up timing then 100 identical cycles
        arm = 1;
        cyc(); chk("arm.c1", 32'(state_w), 32'd1);
        cyc(); chk("arm.c2", 32'(state_w), 32'd1);
        cyc(); chk("arm.c3", 32'(state_w), 32'd2);
        for (int i = 0; i < 100; i++) begin
            pattern(i);
            cyc();
        end
        chk("run100.match_w", 32'(match_w), 32'd47);
        chk("run100.match_n", 32'(match_n), 32'd15);
        chk("run100.div",     32'(div_w),   32'd0);

        // Disarm in CHECK, then mismatches in IDLE and WARMUP are ignored
        arm = 0; idle_inputs();
        cyc();
        chk("disarm.state", 32'(state_w), 32'd0);
        chk("disarm.match", 32'(match_w), 32'd0);
        ivalid_a = 1;
        cyc();
        chk("idle_mm.state", 32'(state_w), 32'd0);
        arm = 1;
        cyc(); cyc(); cyc();
        chk("warm_mm.state", 32'(state_w), 32'd2);
        chk("warm_mm.div",   32'(div_w),   32'd0);
        idle_inputs();
        cyc();
        // Mismatch and disarm together: divergence wins
        ivalid_a = 1; arm = 0;
        cyc();
        chk("both.state", 32'(state_w), 32'd3);
        chk("both.cause", 32'(cause_w), 32'd1);

        // ivalid mismatch in CHECK cycle 5, then hold after disarm
        do_reset();
        arm_to_check();
        for (int i = 0; i < 5; i++) begin
            pattern(i);
            cyc();
        end
        idle_inputs(); ivalid_a = 1;
        cyc();
        chk("c5.state",  32'(state_w),  32'd3);
        chk("c5.cause",  32'(cause_w),  32'd1);
        chk("c5.divcyc", 32'(divcyc_w), 32'd5);
        arm = 0; idle_inputs();
        cyc(); cyc(); cyc();
        chk("hold.state",  32'(state_w),  32'd3);
        chk("hold.divcyc", 32'(divcyc_w), 32'd5);
        chk("hold.match",  32'(match_w),  32'd2);
        rst = 1;
        cyc();
        rst = 0;
        chk("rstdiv.state",  32'(state_w),  32'd0);
        chk("rstdiv.div",    32'(div_w),    32'd0);
        chk("rstdiv.cause",  32'(cause_w),  32'd0);
        chk("rstdiv.divcyc", 32'(divcyc_w), 32'd0);

        // daddr and iaddr differ together
        arm_to_check();
        ivalid_a = 1; ivalid_b = 1; iaddr_a = 32'h10; iaddr_b = 32'h14;
        dvalid_a = 1; dvalid_b = 1; daddr_a = 32'h100; daddr_b = 32'h104;
        cyc();
        chk("addr.cause",  32'(cause_w),  32'b01010);
        chk("addr.divcyc", 32'(divcyc_w), 32'd0);

        // Store data differs
        do_reset();
        arm_to_check();
        dvalid_a = 1; dvalid_b = 1; dwrite_a = 1; dwrite_b = 1;
        daddr_a = 32'h200; daddr_b = 32'h200; dwdata_a = 32'h1; dwdata_b = 32'h2;
        cyc();
`ifdef MITER_DWDATA_CMP_EN
        chk("wdata.state", 32'(state_w), 32'd3);
        chk("wdata.cause", 32'(cause_w), 32'b10000);
`else
        chk("wdata.state", 32'(state_w), 32'd2);
        chk("wdata.div",   32'(div_w),   32'd0);
`endif
        idle_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
